rst_seq_ctl: RTL

RST_SEQ_CTL -- requirements
Module: RST_SEQ_CTL

---
 rtl/rst_seq_pkg.sv | 28 ++
 rtl/rst_seq_ctl_if.sv | 28 ++
 rtl/rst_seq_cnt.sv | 29 ++
 rtl/rst_seq_ctl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared types, defaults and cfg field layout for the reset sequencer
package rst_seq_pkg;

    localparam int NUM_DOM_DEF = 4;
    localparam int CNT_W_DEF   = 8;

    // Bit positions of the fields inside rst_seq_cfg_reg
    localparam int CFG_EN_LSB   = 0;
    localparam int CFG_POL_LSB  = 4;
    localparam int CFG_HOLD_LSB = 8;
    localparam int CFG_GAP_LSB  = 16;
    localparam int CFG_FLD_W    = 8;

    // Values held while CRCU_RST is high; they define the power-on sequence
    localparam logic [3:0] RST_DOM_EN   = 4'hF;
    localparam logic [3:0] RST_DOM_POL  = 4'hF;
    localparam logic [7:0] RST_HOLD_CYC = 8'd15;
    localparam logic [7:0] RST_GAP_CYC  = 8'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HOLD = 3'd1,
        ST_REL  = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } seq_state_t;

endpackage

// File: rtl/rst_seq_ctl_if.sv
// rtl/rst_seq_ctl_if.sv - request/config/reset-output bundle of the reset sequencer
interface rst_seq_ctl_if import rst_seq_pkg::*; #(
    parameter int NUM_DOM = NUM_DOM_DEF
);

    logic               seq_req;
    logic [31:0]        rst_seq_cfg_reg;
    logic [NUM_DOM-1:0] rst_o;
    logic               busy;
    logic               done;

    modport master (
        output seq_req,
        output rst_seq_cfg_reg,
        input  rst_o,
        input  busy,
        input  done
    );

    modport slave (
        input  seq_req,
        input  rst_seq_cfg_reg,
        output rst_o,
        output busy,
        output done
    );

endinterface

// File: rtl/rst_seq_cnt.sv
// rtl/rst_seq_cnt.sv - loadable hold/gap down-counter that saturates at zero
module rst_seq_cnt #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    assign zero = (cnt == '0);

    // Load has priority; a decrement request at zero is dropped so the count never wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !zero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/rst_seq_ctl.sv
// rtl/rst_seq_ctl.sv - ordered multi-domain reset release sequencer
module rst_seq_ctl import rst_seq_pkg::*; #(
    parameter int NUM_DOM = NUM_DOM_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic         CRCU_CLK,
    input  logic         CRCU_RST,
    rst_seq_ctl_if.slave bus
);

    localparam int               PTR_W    = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_DOM - 1);

    seq_state_t state;
    seq_state_t state_nxt;

    logic [PTR_W-1:0]   ptr;
    logic [NUM_DOM-1:0] sh_en;
    logic [NUM_DOM-1:0] sh_pol;
    logic [7:0]         sh_gap;
    logic [NUM_DOM-1:0] rst_q;

    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;
    logic               cnt_dec;
    logic               cnt_zero;

    logic               seq_start;
    logic               rel_fire;
    logic               ptr_inc;

    logic [NUM_DOM-1:0] cfg_en;
    logic [NUM_DOM-1:0] cfg_pol;
    logic [7:0]         cfg_hold;
    logic [7:0]         unused_cfg_rsvd;

    assign cfg_en          = bus.rst_seq_cfg_reg[CFG_EN_LSB   +: NUM_DOM];
    assign cfg_pol         = bus.rst_seq_cfg_reg[CFG_POL_LSB  +: NUM_DOM];
    assign cfg_hold        = bus.rst_seq_cfg_reg[CFG_HOLD_LSB +: CFG_FLD_W];
    assign unused_cfg_rsvd = bus.rst_seq_cfg_reg[31:24];

    assign bus.rst_o = rst_q;
    assign bus.busy  = (state != ST_IDLE);
    assign bus.done  = (state == ST_DONE);

    // The hold count is shadowed inside the counter itself: it is loaded from cfg on the start edge
    rst_seq_cnt #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(RST_HOLD_CYC))
    ) u_cnt (
        .clk      (CRCU_CLK),
        .rst      (CRCU_RST),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State register; reset parks in HOLD so the power-on release runs without a request
    always_ff @(posedge CRCU_CLK or posedge CRCU_RST) begin
        if (CRCU_RST) begin
            state <= ST_HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        seq_start    = 1'b0;
        rel_fire     = 1'b0;
        ptr_inc      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.seq_req) begin
                    seq_start    = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(cfg_hold);
                    state_nxt    = ST_HOLD;
                end
            end
            ST_HOLD, ST_GAP: begin
                if (cnt_zero) begin
                    state_nxt = ST_REL;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_REL: begin
                rel_fire = 1'b1;
                if (ptr == PTR_LAST) begin
                    state_nxt = ST_DONE;
                end else begin
                    ptr_inc = 1'b1;
                    // A disabled domain still costs its REL cycle but skips the gap
                    if (sh_en[ptr]) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(sh_gap);
                        state_nxt    = ST_GAP;
                    end else begin
                        state_nxt = ST_REL;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Config shadow, domain pointer and the physical reset outputs
    always_ff @(posedge CRCU_CLK or posedge CRCU_RST) begin
        if (CRCU_RST) begin
            ptr    <= '0;
            sh_en  <= NUM_DOM'(RST_DOM_EN);
            sh_pol <= NUM_DOM'(RST_DOM_POL);
            sh_gap <= RST_GAP_CYC;
            rst_q  <= NUM_DOM'(RST_DOM_POL);
        end else begin
            if (seq_start) begin
                ptr    <= '0;
                sh_en  <= cfg_en;
                sh_pol <= cfg_pol;
                sh_gap <= bus.rst_seq_cfg_reg[CFG_GAP_LSB +: CFG_FLD_W];
                // Enabled domains go to their asserted level, disabled ones sit at released level
                rst_q  <= ~(cfg_en ^ cfg_pol);
            end
            if (rel_fire && sh_en[ptr]) begin
                rst_q[ptr] <= ~sh_pol[ptr];
            end
            if (ptr_inc) begin
                ptr <= ptr + PTR_W'(1);
            end
        end
    end

endmodule
